// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared types for the memory port arbiter (owner and FSM state
//           encodings) plus a helper that maps a one-hot grant to an owner.
// Rev     : 1.0  initial release
// ============================================================================
package mips_pkg;

  // Which requester currently holds the memory port
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } arb_owner_e;

  // Arbiter FSM state
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Grants are one-hot, so LS is checked first only for determinism
  function automatic arb_owner_e gnt_to_owner(input logic if_gnt, input logic ls_gnt);
    arb_owner_e own;
    own = OWN_NONE;
    if (ls_gnt) begin
      own = OWN_LS;
    end else if (if_gnt) begin
      own = OWN_IF;
    end
    return own;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_prio_sel.sv
`default_nettype none
// ============================================================================
// Module  : arb_prio_sel
// Brief   : Combinational requester pick. Inside a grant window LS wins over
//           IF, unless the starve flag is raised and IF is waiting. The
//           outputs are one-hot or all zero.
// Rev     : 1.0  initial release
// ============================================================================
module arb_prio_sel (
  input  logic if_req_i,
  input  logic ls_req_i,
  input  logic win_i,
  input  logic starve_i,
  output logic if_gnt_o,
  output logic ls_gnt_o
);

  // Priority pick: starved IF first, then LS, then IF
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (win_i) begin
      if (starve_i && if_req_i) begin
        if_gnt_o = 1'b1;
      end else if (ls_req_i) begin
        ls_gnt_o = 1'b1;
      end else if (if_req_i) begin
        if_gnt_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares one fixed-latency single-ported memory between instruction
//           fetch (IF) and load/store (LS). One access in flight; grant ->
//           MEM_LAT-cycle count -> rvalid to the owner. A new grant may be
//           issued in the completion cycle, giving one access per MEM_LAT.
//           Optional macro MEM_PORT_ARB_STARVE_GUARD_EN adds a 3-bit
//           saturating starve counter that forces an IF grant after
//           STARVE_MAX consecutive LS grants while IF waits.
// Rev     : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned c_CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [c_CNT_W-1:0] c_LAT_LOAD = c_CNT_W'(MEM_LAT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  // Zero latency has no completion cycle and a zero threshold would starve LS
  generate
    if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
      $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must both be >= 1");
    end
  endgenerate

  arb_state_e         state_q, state_d;
  arb_owner_e         owner_q, owner_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;

  logic w_win;
  logic w_done;
  logic w_starve;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_any_gnt;

  // Completion cycle of the access in flight
  assign w_done    = (state_q == ARB_BUSY) && (cnt_q == c_CNT_ONE);
  // Grants are suppressed while reset is asserted so all outputs read zero
  assign w_win     = rst_n && ((state_q == ARB_IDLE) || w_done);
  assign w_any_gnt = w_if_gnt | w_ls_gnt;

  arb_prio_sel u_prio_sel (
    .if_req_i (if_req),
    .ls_req_i (ls_req),
    .win_i    (w_win),
    .starve_i (w_starve),
    .if_gnt_o (w_if_gnt),
    .ls_gnt_o (w_ls_gnt)
  );

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;

  // Count LS wins while IF waits; an IF grant clears the count
  always_comb begin
    starve_d = starve_q;
    if (w_if_gnt) begin
      starve_d = 3'd0;
    end else if (w_ls_gnt && if_req && (starve_q != 3'd7)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // Starve counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign w_starve = (32'(starve_q) >= STARVE_MAX);
`else
  assign w_starve = 1'b0;
`endif

  // Next-state: grant reloads the counter, completion without grant idles
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (w_any_gnt) begin
      state_d = ARB_BUSY;
      owner_d = gnt_to_owner(w_if_gnt, w_ls_gnt);
      cnt_d   = c_LAT_LOAD;
    end else if (state_q == ARB_BUSY) begin
      if (cnt_q == c_CNT_ONE) begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - c_CNT_ONE;
      end
    end
  end

  // FSM, owner and latency counter registers; reset aborts any access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory-side request mux; unused fields are forced to zero
  always_comb begin
    mem_en    = w_any_gnt;
    mem_we    = w_ls_gnt & ls_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_ls_gnt) begin
      mem_addr = ls_addr;
      if (ls_we) begin
        mem_wdata = ls_wdata;
      end
    end else if (w_if_gnt) begin
      mem_addr = if_addr;
    end
  end

  assign if_gnt    = w_if_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign if_rvalid = w_done && (owner_q == OWN_IF);
  assign ls_rvalid = w_done && (owner_q == OWN_LS);
  // Read data is only meaningful alongside the matching rvalid
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule
`default_nettype wire
